// File: rtl/router_pkg.sv
// Shared types for the registered mesh router: port enum, config word layout.
// Latency: n/a (types only).
// Backpressure: n/a; the mesh has no flow control.
package router_pkg;

  // Port numbering is also the bit order of dest_mask and of the per-router
  // 4-lane data/enable vectors.
  typedef enum logic [1:0] {
    PORT_N = 2'd0,
    PORT_S = 2'd1,
    PORT_W = 2'd2,
    PORT_E = 2'd3
  } port_e;

  localparam int CFG_WIDTH = 6;
  localparam int NUM_PORTS = 4;

  typedef struct packed {
    port_e      src;
    logic [3:0] dest_mask;
  } cfg_t;

endpackage

// File: rtl/router_reg.sv
// Single mesh router: one selected input fanned out to masked outputs, each output registered.
// Latency: 1 clk from enable_i/data_i to enable_o/data_o.
// Backpressure: none; every enabled word is forwarded on the next edge.
// Ports: clk, reset (sync, active-high); cfg_we/cfg_data write the shadow config,
//        cfg_commit copies shadow to active; data_i/enable_i and data_o/enable_o
//        are 4 lanes ordered N,S,W,E, lane p at [p*DATA_WIDTH +: DATA_WIDTH].
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_we,
  input  logic [CFG_WIDTH-1:0]            cfg_data,
  input  logic                            cfg_commit,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_PORTS-1:0]            enable_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_o,
  output logic [NUM_PORTS-1:0]            enable_o
);

  cfg_t                  shadow_cfg;
  cfg_t                  active_cfg;
  logic [1:0]            src_idx;
  logic [DATA_WIDTH-1:0] src_dat;
  logic                  src_en;
  logic [NUM_PORTS-1:0]  next_en;

  always_comb begin
    src_idx = active_cfg.src;
    src_dat = data_i[src_idx*DATA_WIDTH +: DATA_WIDTH];
    src_en  = enable_i[src_idx];
    next_en = '0;
    // A mask bit pointing back at the source port (U-turn) is ignored.
    for (int p = 0; p < NUM_PORTS; p++) begin
      next_en[p] = src_en & active_cfg.dest_mask[p] & (src_idx != 2'(p));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_cfg <= '0;
      active_cfg <= '0;
      enable_o   <= '0;
      data_o     <= '0;
    end else begin
      // Commit reads the pre-write shadow, so a same-cycle write only lands in shadow.
      if (cfg_commit) active_cfg <= shadow_cfg;
      if (cfg_we)     shadow_cfg <= cfg_t'(cfg_data);
      enable_o <= next_en;
      // Data registers hold their last word while their output is idle.
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (next_en[p]) data_o[p*DATA_WIDTH +: DATA_WIDTH] <= src_dat;
      end
    end
  end

endmodule

// File: rtl/router_mesh_n.sv
// ROWS x COLS mesh of registered routers; row 0 north, column 0 west.
// Latency: 1 clk per router traversed (H hops -> H cycles), one word/cycle/link.
// Backpressure: none; sinks must accept every enabled word.
// Ports: clk, reset (sync, active-high); cfg_we/cfg_addr/cfg_data write one router's
//        shadow config (index r*COLS+c, out-of-range ignored); cfg_commit activates all;
//        <edge>_data_i/_enable_i and <edge>_data_o/_enable_o per mesh edge, lane k at
//        [k*DATA_WIDTH +: DATA_WIDTH] (north/south: COLS lanes, west/east: ROWS lanes).
module router_mesh_n
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  localparam int NR        = ROWS * COLS,
  localparam int AW        = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [CFG_WIDTH-1:0]       cfg_data,
  input  logic                       cfg_commit,
  input  logic [COLS*DATA_WIDTH-1:0] north_data_i,
  input  logic [COLS-1:0]            north_enable_i,
  output logic [COLS*DATA_WIDTH-1:0] north_data_o,
  output logic [COLS-1:0]            north_enable_o,
  input  logic [COLS*DATA_WIDTH-1:0] south_data_i,
  input  logic [COLS-1:0]            south_enable_i,
  output logic [COLS*DATA_WIDTH-1:0] south_data_o,
  output logic [COLS-1:0]            south_enable_o,
  input  logic [ROWS*DATA_WIDTH-1:0] west_data_i,
  input  logic [ROWS-1:0]            west_enable_i,
  output logic [ROWS*DATA_WIDTH-1:0] west_data_o,
  output logic [ROWS-1:0]            west_enable_o,
  input  logic [ROWS*DATA_WIDTH-1:0] east_data_i,
  input  logic [ROWS-1:0]            east_enable_i,
  output logic [ROWS*DATA_WIDTH-1:0] east_data_o,
  output logic [ROWS-1:0]            east_enable_o
);

  localparam int DW = DATA_WIDTH;
  localparam int PN = int'(PORT_N);
  localparam int PS = int'(PORT_S);
  localparam int PW = int'(PORT_W);
  localparam int PE = int'(PORT_E);

  logic [NUM_PORTS*DW-1:0] r_din  [NR];
  logic [NUM_PORTS-1:0]    r_ein  [NR];
  logic [NUM_PORTS*DW-1:0] r_dout [NR];
  logic [NUM_PORTS-1:0]    r_eout [NR];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int I = r * COLS + c;

      // North side: mesh edge on row 0, otherwise the south output of the router above.
      if (r == 0) begin : g_n_edge
        assign r_din[I][PN*DW +: DW]     = north_data_i[c*DW +: DW];
        assign r_ein[I][PN]              = north_enable_i[c];
        assign north_data_o[c*DW +: DW]  = r_dout[I][PN*DW +: DW];
        assign north_enable_o[c]         = r_eout[I][PN];
      end else begin : g_n_link
        assign r_din[I][PN*DW +: DW]     = r_dout[I-COLS][PS*DW +: DW];
        assign r_ein[I][PN]              = r_eout[I-COLS][PS];
      end

      if (r == ROWS - 1) begin : g_s_edge
        assign r_din[I][PS*DW +: DW]     = south_data_i[c*DW +: DW];
        assign r_ein[I][PS]              = south_enable_i[c];
        assign south_data_o[c*DW +: DW]  = r_dout[I][PS*DW +: DW];
        assign south_enable_o[c]         = r_eout[I][PS];
      end else begin : g_s_link
        assign r_din[I][PS*DW +: DW]     = r_dout[I+COLS][PN*DW +: DW];
        assign r_ein[I][PS]              = r_eout[I+COLS][PN];
      end

      if (c == 0) begin : g_w_edge
        assign r_din[I][PW*DW +: DW]     = west_data_i[r*DW +: DW];
        assign r_ein[I][PW]              = west_enable_i[r];
        assign west_data_o[r*DW +: DW]   = r_dout[I][PW*DW +: DW];
        assign west_enable_o[r]          = r_eout[I][PW];
      end else begin : g_w_link
        assign r_din[I][PW*DW +: DW]     = r_dout[I-1][PE*DW +: DW];
        assign r_ein[I][PW]              = r_eout[I-1][PE];
      end

      if (c == COLS - 1) begin : g_e_edge
        assign r_din[I][PE*DW +: DW]     = east_data_i[r*DW +: DW];
        assign r_ein[I][PE]              = east_enable_i[r];
        assign east_data_o[r*DW +: DW]   = r_dout[I][PE*DW +: DW];
        assign east_enable_o[r]          = r_eout[I][PE];
      end else begin : g_e_link
        assign r_din[I][PE*DW +: DW]     = r_dout[I+1][PW*DW +: DW];
        assign r_ein[I][PE]              = r_eout[I+1][PW];
      end

      // Widened compare so addresses past the last router never match.
      router_reg #(
        .DATA_WIDTH(DW)
      ) u_router (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we && (32'(cfg_addr) == I)),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .data_i     (r_din[I]),
        .enable_i   (r_ein[I]),
        .data_o     (r_dout[I]),
        .enable_o   (r_eout[I])
      );
    end
  end

endmodule

// File: tb/tb_router_mesh_n.sv
module tb_router_mesh_n;
  localparam int DW = 16;

  // Config words {src[1:0], mask[3:0]}; src N=0 S=1 W=2 E=3, mask bits [0]N [1]S [2]W [3]E.
  localparam logic [5:0] CFG_W_E   = 6'h28;
  localparam logic [5:0] CFG_W_ES  = 6'h2A;
  localparam logic [5:0] CFG_N_W   = 6'h04;
  localparam logic [5:0] CFG_W_S   = 6'h22;
  localparam logic [5:0] CFG_N_S   = 6'h02;
  localparam logic [5:0] CFG_W_W   = 6'h24;
  localparam logic [5:0] CFG_W_ALL = 6'h2F;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 2x2 mesh
  logic            a_cfg_we, a_cfg_commit;
  logic [1:0]      a_cfg_addr;
  logic [5:0]      a_cfg_data;
  logic [2*DW-1:0] a_n_dat_i, a_s_dat_i, a_w_dat_i, a_e_dat_i;
  logic [2*DW-1:0] a_n_dat_o, a_s_dat_o, a_w_dat_o, a_e_dat_o;
  logic [1:0]      a_n_en_i, a_s_en_i, a_w_en_i, a_e_en_i;
  logic [1:0]      a_n_en_o, a_s_en_o, a_w_en_o, a_e_en_o;

  // 3x4 mesh: north/south 4 lanes, west/east 3 lanes
  logic            b_cfg_we, b_cfg_commit;
  logic [3:0]      b_cfg_addr;
  logic [5:0]      b_cfg_data;
  logic [4*DW-1:0] b_n_dat_i, b_s_dat_i, b_n_dat_o, b_s_dat_o;
  logic [3:0]      b_n_en_i, b_s_en_i, b_n_en_o, b_s_en_o;
  logic [3*DW-1:0] b_w_dat_i, b_e_dat_i, b_w_dat_o, b_e_dat_o;
  logic [2:0]      b_w_en_i, b_e_en_i, b_w_en_o, b_e_en_o;

  router_mesh_n #(.DATA_WIDTH(DW), .ROWS(2), .COLS(2)) dut_a (
    .clk(clk), .reset(reset),
    .cfg_we(a_cfg_we), .cfg_addr(a_cfg_addr), .cfg_data(a_cfg_data), .cfg_commit(a_cfg_commit),
    .north_data_i(a_n_dat_i), .north_enable_i(a_n_en_i), .north_data_o(a_n_dat_o), .north_enable_o(a_n_en_o),
    .south_data_i(a_s_dat_i), .south_enable_i(a_s_en_i), .south_data_o(a_s_dat_o), .south_enable_o(a_s_en_o),
    .west_data_i(a_w_dat_i),  .west_enable_i(a_w_en_i),  .west_data_o(a_w_dat_o),  .west_enable_o(a_w_en_o),
    .east_data_i(a_e_dat_i),  .east_enable_i(a_e_en_i),  .east_data_o(a_e_dat_o),  .east_enable_o(a_e_en_o)
  );

  router_mesh_n #(.DATA_WIDTH(DW), .ROWS(3), .COLS(4)) dut_b (
    .clk(clk), .reset(reset),
    .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data), .cfg_commit(b_cfg_commit),
    .north_data_i(b_n_dat_i), .north_enable_i(b_n_en_i), .north_data_o(b_n_dat_o), .north_enable_o(b_n_en_o),
    .south_data_i(b_s_dat_i), .south_enable_i(b_s_en_i), .south_data_o(b_s_dat_o), .south_enable_o(b_s_en_o),
    .west_data_i(b_w_dat_i),  .west_enable_i(b_w_en_i),  .west_data_o(b_w_dat_o),  .west_enable_o(b_w_en_o),
    .east_data_i(b_e_dat_i),  .east_enable_i(b_e_en_i),  .east_data_o(b_e_dat_o),  .east_enable_o(b_e_en_o)
  );

  wire [7:0]  a_en_all  = {a_n_en_o, a_s_en_o, a_w_en_o, a_e_en_o};
  wire        a_dat_any = |{a_n_dat_o, a_s_dat_o, a_w_dat_o, a_e_dat_o};
  wire [13:0] b_en_all  = {b_n_en_o, b_s_en_o, b_w_en_o, b_e_en_o};
  wire        b_dat_any = |{b_n_dat_o, b_s_dat_o, b_w_dat_o, b_e_dat_o};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    a_cfg_we = 0; a_cfg_commit = 0; a_cfg_addr = '0; a_cfg_data = '0;
    a_n_dat_i = '0; a_s_dat_i = '0; a_w_dat_i = '0; a_e_dat_i = '0;
    a_n_en_i = '0;  a_s_en_i = '0;  a_w_en_i = '0;  a_e_en_i = '0;
    b_cfg_we = 0; b_cfg_commit = 0; b_cfg_addr = '0; b_cfg_data = '0;
    b_n_dat_i = '0; b_s_dat_i = '0; b_w_dat_i = '0; b_e_dat_i = '0;
    b_n_en_i = '0;  b_s_en_i = '0;  b_w_en_i = '0;  b_e_en_i = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic a_cfg(input logic [1:0] addr, input logic [5:0] d);
    a_cfg_we = 1; a_cfg_addr = addr; a_cfg_data = d;
    tick;
    a_cfg_we = 0;
  endtask

  task automatic a_commit;
    a_cfg_commit = 1;
    tick;
    a_cfg_commit = 0;
  endtask

  task automatic b_cfg(input logic [3:0] addr, input logic [5:0] d);
    b_cfg_we = 1; b_cfg_addr = addr; b_cfg_data = d;
    tick;
    b_cfg_we = 0;
  endtask

  task automatic b_commit;
    b_cfg_commit = 1;
    tick;
    b_cfg_commit = 0;
  endtask

  initial begin
    clear_in;
    do_reset;
    check_eq("rst_a_en", a_en_all, 8'h00);
    check_eq("rst_a_dat", a_dat_any, 1'b0);
    check_eq("rst_b_en", b_en_all, 14'h0);
    check_eq("rst_b_dat", b_dat_any, 1'b0);

    // No output after reset until a config is written and committed.
    a_n_en_i = 2'b11; a_s_en_i = 2'b11; a_w_en_i = 2'b11; a_e_en_i = 2'b11;
    a_w_dat_i = 32'hFFFF_FFFF; a_n_dat_i = 32'hAAAA_AAAA;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_eq($sformatf("noconf_en_%0d", i), a_en_all, 8'h00);
    end
    clear_in;

    // Two-hop straight path west lane0 -> east lane0.
    do_reset;
    a_cfg(2'd0, CFG_W_E);
    a_cfg(2'd1, CFG_W_E);
    a_commit;
    a_w_dat_i[15:0] = 16'h1234; a_w_en_i = 2'b01;
    tick;
    clear_in;
    check_eq("path_hop1_en", a_e_en_o, 2'b00);
    tick;
    check_eq("path_hop2_en", a_e_en_o, 2'b01);
    check_eq("path_hop2_dat", a_e_dat_o[15:0], 16'h1234);
    tick;
    check_eq("path_after_en", a_e_en_o, 2'b00);

    // Multicast: router0 forks E and S; both branches exit after two hops.
    do_reset;
    a_cfg(2'd0, CFG_W_ES);
    a_cfg(2'd1, CFG_W_E);
    a_cfg(2'd2, CFG_N_W);
    a_commit;
    a_w_dat_i[15:0] = 16'hBEEF; a_w_en_i = 2'b01;
    tick;
    clear_in;
    check_eq("mc_hop1_w_en", a_w_en_o, 2'b00);
    tick;
    check_eq("mc_e_en", a_e_en_o, 2'b01);
    check_eq("mc_e_dat", a_e_dat_o[15:0], 16'hBEEF);
    check_eq("mc_w_en", a_w_en_o, 2'b10);
    check_eq("mc_w_dat", a_w_dat_o[31:16], 16'hBEEF);

    // Commit timing: word k enters before edge k. Edge 3 writes shadow={W,S} with
    // a simultaneous commit (active keeps {W,E}); edge 5 commits it, so word 5
    // still goes east and word 6 onward leaves router0 southward.
    do_reset;
    a_cfg(2'd0, CFG_W_E);
    a_cfg(2'd1, CFG_W_E);
    a_cfg(2'd2, CFG_N_S);
    a_commit;
    for (int e = 1; e <= 9; e++) begin
      logic exp_e, exp_s;
      a_w_en_i     = (e <= 7) ? 2'b01 : 2'b00;
      a_w_dat_i    = (e <= 7) ? {16'h0, 16'(e)} : 32'h0;
      a_cfg_we     = (e == 3);
      a_cfg_addr   = 2'd0;
      a_cfg_data   = CFG_W_S;
      a_cfg_commit = (e == 3) || (e == 5);
      tick;
      exp_e = (e >= 2) && (e <= 6);
      exp_s = (e >= 7) && (e <= 8);
      check_eq($sformatf("commit_e_en_%0d", e), a_e_en_o[0], exp_e);
      check_eq($sformatf("commit_s_en_%0d", e), a_s_en_o[0], exp_s);
      if (exp_e) check_eq($sformatf("commit_e_dat_%0d", e), a_e_dat_o[15:0], 16'(e - 1));
      if (exp_s) check_eq($sformatf("commit_s_dat_%0d", e), a_s_dat_o[15:0], 16'(e - 1));
    end
    clear_in;

    // U-turn mask bit is ignored: nothing ever returns on the west edge.
    do_reset;
    a_cfg(2'd0, CFG_W_W);
    a_commit;
    a_w_en_i = 2'b01; a_w_dat_i = 32'h0000_5555;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_eq($sformatf("uturn_en_%0d", i), a_en_all, 8'h00);
    end
    clear_in;

    // Reset mid-stream dominates cfg writes, commit and traffic.
    do_reset;
    for (int i = 0; i < 4; i++) a_cfg(2'(i), CFG_W_E);
    a_commit;
    a_w_en_i = 2'b11; a_w_dat_i = 32'h0021_0011;
    tick;
    a_w_dat_i = 32'h0022_0012;
    tick;
    check_eq("midrst_pre_en", a_e_en_o, 2'b11);
    check_eq("midrst_pre_dat", a_e_dat_o, 32'h0021_0011);
    reset = 1'b1;
    a_cfg_we = 1; a_cfg_addr = 2'd0; a_cfg_data = CFG_W_ALL; a_cfg_commit = 1;
    a_w_dat_i = 32'h0023_0013;
    tick;
    check_eq("midrst_en", a_en_all, 8'h00);
    check_eq("midrst_dat", a_dat_any, 1'b0);
    reset = 1'b0;
    a_cfg_we = 0; a_cfg_commit = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check_eq($sformatf("postrst_en_%0d", i), a_en_all, 8'h00);
    end
    clear_in;

    // 3x4: out-of-range addresses (12 and 15; the 2x2 address field is only 2 bits
    // wide so it has none) must leave every router isolated.
    do_reset;
    b_cfg(4'd12, CFG_W_ALL);
    b_cfg(4'd15, CFG_W_ALL);
    b_commit;
    b_n_en_i = 4'hF; b_s_en_i = 4'hF; b_w_en_i = 3'b111; b_e_en_i = 3'b111;
    b_w_dat_i = 48'h3333_2222_1111; b_n_dat_i = 64'h4444_4444_4444_4444;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_eq($sformatf("oor_en_%0d", i), b_en_all, 14'h0);
    end
    clear_in;

    // 3x4: row 1 straight west to east, four hops, lane 1 at bits [16 +: 16].
    for (int i = 4; i < 8; i++) b_cfg(4'(i), CFG_W_E);
    b_commit;
    b_w_dat_i[16 +: 16] = 16'hA5A5; b_w_en_i = 3'b010;
    tick;
    clear_in;
    check_eq("row1_e_en_1", b_e_en_o, 3'b000);
    for (int e = 2; e <= 5; e++) begin
      tick;
      check_eq($sformatf("row1_e_en_%0d", e), b_e_en_o, (e == 4) ? 3'b010 : 3'b000);
      if (e == 4) check_eq("row1_e_dat", b_e_dat_o[16 +: 16], 16'hA5A5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
